// File: rtl/ila_readout_ctrl.sv
// ila_readout_ctrl: readout sequencer for the ILA sample buffer.
// Walks every captured entry and every DATA_W slice of it through the core's
// index/value_select port, waits READ_LAT cycles per word and streams the
// result out on a valid/ready master port.
// Optional leading header beat (captured sample count): define
// ILA_READOUT_CTRL_HEADER_EN.
module ila_readout_ctrl #(
  parameter int DATA_W   = 32,
  parameter int BUFFER_W = 10,
  parameter int SEL_W    = 1,
  parameter int WORDS    = 1,
  parameter int READ_LAT = 2
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [BUFFER_W-1:0] samples_i,
  output logic [BUFFER_W-1:0] index_o,
  output logic [SEL_W-1:0]    value_select_o,
  input  logic [DATA_W-1:0]   value_i,
  output logic [DATA_W-1:0]   m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                m_last_o,
  output logic                busy_o,
  output logic                done_o
);

  // Wait counter has to reach READ_LAT itself
  localparam int CNT_W = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WORDS - 1);

`ifdef ILA_READOUT_CTRL_HEADER_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_WAIT = 2'd2, S_OUT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd2, S_OUT = 2'd3} state_t;
`endif

  state_t r_state;
  state_t w_state_next;

  logic [BUFFER_W-1:0] r_n_lat, w_n_lat_next;
  logic [BUFFER_W-1:0] r_index, w_index_next;
  logic [SEL_W-1:0]    r_sel, w_sel_next;
  logic [CNT_W-1:0]    r_wait_cnt, w_wait_cnt_next;
  logic [DATA_W-1:0]   r_data, w_data_next;
  logic                r_valid, w_valid_next;
  logic                r_last, w_last_next;
  logic                r_busy, w_busy_next;
  logic                r_done, w_done_next;
  logic                w_hs;

  assign w_hs = r_valid & m_ready_i;

  // State register; cke_i low freezes the sequencer
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= S_IDLE;
    end else if (cke_i) begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; abort overrides every other event, including start
  always_comb begin
    w_state_next = r_state;
    if (abort_i) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
`ifdef ILA_READOUT_CTRL_HEADER_EN
            w_state_next = S_HDR;
`else
            if (samples_i != '0) w_state_next = S_WAIT;
`endif
          end
        end
`ifdef ILA_READOUT_CTRL_HEADER_EN
        S_HDR:   if (w_hs) w_state_next = r_last ? S_IDLE : S_WAIT;
`endif
        S_WAIT:  if (r_wait_cnt == CNT_LAST) w_state_next = S_OUT;
        S_OUT:   if (w_hs) w_state_next = r_last ? S_IDLE : S_WAIT;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Next values of the address walk, wait counter and stream outputs
  always_comb begin
    w_n_lat_next    = r_n_lat;
    w_index_next    = r_index;
    w_sel_next      = r_sel;
    w_wait_cnt_next = r_wait_cnt;
    w_data_next     = r_data;
    w_valid_next    = r_valid;
    w_last_next     = r_last;
    w_done_next     = 1'b0;
    if (abort_i) begin
      w_valid_next = 1'b0;
      w_last_next  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            // Snapshot the count so later core writes cannot stretch the walk
            w_n_lat_next    = samples_i;
            w_index_next    = '0;
            w_sel_next      = '0;
            w_wait_cnt_next = '0;
`ifdef ILA_READOUT_CTRL_HEADER_EN
            w_data_next  = DATA_W'(samples_i);
            w_valid_next = 1'b1;
            w_last_next  = (samples_i == '0);
`else
            w_done_next  = (samples_i == '0);
`endif
          end
        end
`ifdef ILA_READOUT_CTRL_HEADER_EN
        S_HDR: begin
          if (w_hs) begin
            w_valid_next = 1'b0;
            w_last_next  = 1'b0;
            w_done_next  = r_last;
          end
        end
`endif
        S_WAIT: begin
          if (r_wait_cnt == CNT_LAST) begin
            w_data_next  = value_i;
            w_valid_next = 1'b1;
            w_last_next  = (r_index == r_n_lat - BUFFER_W'(1)) && (r_sel == SEL_LAST);
          end else begin
            w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
          end
        end
        S_OUT: begin
          if (w_hs) begin
            w_valid_next    = 1'b0;
            w_last_next     = 1'b0;
            w_wait_cnt_next = '0;
            if (r_last) begin
              w_done_next = 1'b1;
            end else if (r_sel == SEL_LAST) begin
              w_sel_next   = '0;
              w_index_next = r_index + BUFFER_W'(1);
            end else begin
              w_sel_next = r_sel + SEL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
    w_busy_next = (w_state_next != S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_n_lat    <= '0;
      r_index    <= '0;
      r_sel      <= '0;
      r_wait_cnt <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (cke_i) begin
      r_n_lat    <= w_n_lat_next;
      r_index    <= w_index_next;
      r_sel      <= w_sel_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_data     <= w_data_next;
      r_valid    <= w_valid_next;
      r_last     <= w_last_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign index_o        = r_index;
  assign value_select_o = r_sel;
  assign m_data_o       = r_data;
  assign m_valid_o      = r_valid;
  assign m_last_o       = r_last;
  assign busy_o         = r_busy;
  assign done_o         = r_done;

endmodule

// File: tb/tb_ila_readout_ctrl.sv
// tb_ila_readout_ctrl: two sequencers (1 and 3 words per sample) share the
// same stimulus; each reads a small latency-pipelined core model.
`timescale 1ns/1ps
module tb_ila_readout_ctrl;
  localparam int DATA_W   = 32;
  localparam int BUFFER_W = 10;
  localparam int READ_LAT = 2;
`ifdef ILA_READOUT_CTRL_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk_i = 1'b0;
  logic arst_i = 1'b1;
  logic cke_i = 1'b1;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic m_ready_i = 1'b0;
  logic [BUFFER_W-1:0] samples_i = '0;

  logic [BUFFER_W-1:0] idx1, idx3;
  logic [0:0]          sel1;
  logic [1:0]          sel3;
  logic [DATA_W-1:0]   val1, val3;
  logic [DATA_W-1:0]   dat [2];
  logic                vld [2];
  logic                lst [2];
  logic                bsy [2];
  logic                dn  [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  ila_readout_ctrl #(.DATA_W(DATA_W), .BUFFER_W(BUFFER_W), .SEL_W(1), .WORDS(1), .READ_LAT(READ_LAT)) dut1 (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .start_i(start_i), .abort_i(abort_i),
    .samples_i(samples_i), .index_o(idx1), .value_select_o(sel1), .value_i(val1),
    .m_data_o(dat[0]), .m_valid_o(vld[0]), .m_ready_i(m_ready_i), .m_last_o(lst[0]),
    .busy_o(bsy[0]), .done_o(dn[0]));

  ila_readout_ctrl #(.DATA_W(DATA_W), .BUFFER_W(BUFFER_W), .SEL_W(2), .WORDS(3), .READ_LAT(READ_LAT)) dut3 (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .start_i(start_i), .abort_i(abort_i),
    .samples_i(samples_i), .index_o(idx3), .value_select_o(sel3), .value_i(val3),
    .m_data_o(dat[1]), .m_valid_o(vld[1]), .m_ready_i(m_ready_i), .m_last_o(lst[1]),
    .busy_o(bsy[1]), .done_o(dn[1]));

  // Core model: address goes through READ_LAT register stages before the word appears
  logic [BUFFER_W-1:0] p1 [READ_LAT];
  logic [BUFFER_W+1:0] p3 [READ_LAT];
  always @(posedge clk_i) begin
    p1[0] <= idx1;
    p3[0] <= {sel3, idx3};
    for (int i = 1; i < READ_LAT; i++) begin
      p1[i] <= p1[i-1];
      p3[i] <= p3[i-1];
    end
  end
  assign val1 = 32'(p1[READ_LAT-1]) * 32'd3;
  assign val3 = (32'(p3[READ_LAT-1][BUFFER_W-1:0]) << 8) | 32'(p3[READ_LAT-1][BUFFER_W+1:BUFFER_W]);

  // Word the core holds at (index, select) for a given words-per-sample
  function automatic logic [31:0] core_word(input int w, input int idx, input int sel);
    if (w == 1) return 32'(idx * 3);
    return 32'((idx << 8) | sel);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Captured beats per DUT: {last, data} and handshake cycle
  logic [32:0] bq [2][64];
  int          bc [2][64];
  int          nb [2];
  int          dcnt [2];
  int          dcyc [2];

  // One readout: start with n, change samples_i to n_after, optional random
  // ready/cke, optional abort (with start held) after abort_after data beats
  task automatic run(input int n, input int n_after, input bit rnd, input int abort_after);
    int t0, phase, k, w, exp_n, exp_hc, exp_dc;
    bit fin;
    logic [31:0] pd [2];
    logic        pl [2];
    bit          hold [2];
    logic [31:0] ed;
    logic        el;
    phase = 0; fin = 0;
    for (int d = 0; d < 2; d++) begin
      nb[d] = 0; dcnt[d] = 0; dcyc[d] = -1; hold[d] = 0; pd[d] = '0; pl[d] = 0;
    end
    @(posedge clk_i); #1;
    start_i = 1; abort_i = 0; samples_i = BUFFER_W'(n); m_ready_i = 1; cke_i = 1; t0 = cyc;
    @(posedge clk_i); #1;
    start_i = 0; samples_i = BUFFER_W'(n_after);
    for (int c = 1; c < 2000 && !fin; c++) begin
      if (c > 1) begin @(posedge clk_i); #1; end
      m_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      cke_i     = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      if (phase == 1) begin
        abort_i = 1; start_i = 1; samples_i = BUFFER_W'(n); phase = 2;
      end else if (phase == 2) begin
        abort_i = 0; start_i = 0; phase = 3;
      end
      @(negedge clk_i);
      if (phase == 3) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("abort_busy%0d", d), bsy[d], 0);
          chk($sformatf("abort_valid%0d", d), vld[d], 0);
          chk($sformatf("abort_last%0d", d), lst[d], 0);
          chk($sformatf("abort_done%0d", d), dn[d], 0);
        end
        repeat (4) begin
          @(negedge clk_i);
          for (int d = 0; d < 2; d++) begin
            chk($sformatf("post_abort_valid%0d", d), vld[d], 0);
            chk($sformatf("post_abort_done%0d", d), dn[d], 0);
          end
        end
        fin = 1;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (hold[d]) begin
            chk($sformatf("hold_valid%0d", d), vld[d], 1);
            chk($sformatf("hold_data%0d", d), dat[d], pd[d]);
            chk($sformatf("hold_last%0d", d), lst[d], pl[d]);
          end
          hold[d] = vld[d] && !(m_ready_i && cke_i);
          pd[d] = dat[d]; pl[d] = lst[d];
          if (vld[d] && m_ready_i && cke_i && nb[d] < 64) begin
            bq[d][nb[d]] = {lst[d], dat[d]};
            bc[d][nb[d]] = cyc;
            nb[d]++;
          end
          if (dn[d] && cke_i) begin
            dcnt[d]++; dcyc[d] = cyc;
            chk($sformatf("busy_at_done%0d", d), bsy[d], 0);
          end
        end
        if (dcnt[0] > 0 && dcnt[1] > 0) fin = 1;
        if (abort_after >= 0 && phase == 0 && nb[0] - HDR == abort_after) phase = 1;
      end
    end
    if (!fin) chk("run_timeout", 0, 1);
    cke_i = 1; m_ready_i = 1;
    if (abort_after < 0) begin
      for (int d = 0; d < 2; d++) begin
        w = (d == 0) ? 1 : 3;
        exp_n = HDR + n * w;
        chk($sformatf("n%0d_beats%0d", n, d), nb[d], exp_n);
        for (int j = 0; j < nb[d] && j < exp_n; j++) begin
          if (HDR == 1 && j == 0) begin
            ed = 32'(n); el = (n == 0); exp_hc = t0 + 1;
          end else begin
            k = j - HDR;
            ed = core_word(w, k / w, k % w); el = (k == n * w - 1);
            exp_hc = t0 + HDR + (READ_LAT + 2) * (k + 1);
          end
          chk($sformatf("n%0d_d%0d_beat%0d_data", n, d, j), bq[d][j][31:0], ed);
          chk($sformatf("n%0d_d%0d_beat%0d_last", n, d, j), bq[d][j][32], el);
          if (!rnd) chk($sformatf("n%0d_d%0d_beat%0d_cycle", n, d, j), bc[d][j] - t0, exp_hc - t0);
        end
        chk($sformatf("n%0d_done_count%0d", n, d), dcnt[d], 1);
        if (n == 0) exp_dc = t0 + 1 + HDR;
        else exp_dc = t0 + HDR + (READ_LAT + 2) * (n * w) + 1;
        if (!rnd) chk($sformatf("n%0d_done_cycle%0d", n, d), dcyc[d] - t0, exp_dc - t0);
      end
      repeat (3) begin
        @(negedge clk_i);
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("trail_valid%0d", d), vld[d], 0);
          chk($sformatf("trail_done%0d", d), dn[d], 0);
        end
      end
    end
    $display("run n=%0d n_after=%0d rnd=%0d abort_after=%0d: beats %0d/%0d", n, n_after, rnd, abort_after, nb[0], nb[1]);
  endtask

  typedef struct {
    bit st; bit ab; bit rdy; int smp;
    bit e_busy; bit e_vld; bit e_last; bit e_done; bit c_dat; int e_dat;
  } vec_t;
  vec_t tv [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // stimulus table: inputs held for one cycle, outputs expected in the next
    tv[0] = '{1, 1, 1, 3, 0,   0,   0,   0,       1, 0};
    tv[1] = '{1, 0, 1, 0, HDR, HDR, HDR, 1 - HDR, 1, 0};
    tv[2] = '{0, 0, 1, 0, 0,   0,   0,   HDR,     1, 0};
    tv[3] = '{0, 0, 1, 0, 0,   0,   0,   0,       1, 0};
    tv[4] = '{1, 0, 0, 5, 1,   HDR, 0,   0,       1, HDR * 5};
    tv[5] = '{1, 1, 0, 5, 0,   0,   0,   0,       0, 0};
    tv[6] = '{0, 0, 1, 0, 0,   0,   0,   0,       0, 0};
    tv[7] = '{1, 0, 0, 1, 1,   HDR, 0,   0,       0, 0};
    tv[8] = '{1, 0, 0, 7, 1,   HDR, 0,   0,       0, 0};
    tv[9] = '{0, 1, 0, 0, 0,   0,   0,   0,       0, 0};

    // reset state
    repeat (3) @(negedge clk_i);
    chk("rst_index1", 32'(idx1), 0);
    chk("rst_sel1", 32'(sel1), 0);
    chk("rst_index3", 32'(idx3), 0);
    chk("rst_sel3", 32'(sel3), 0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_data%0d", d), dat[d], 0);
      chk($sformatf("rst_valid%0d", d), vld[d], 0);
      chk($sformatf("rst_last%0d", d), lst[d], 0);
      chk($sformatf("rst_busy%0d", d), bsy[d], 0);
      chk($sformatf("rst_done%0d", d), dn[d], 0);
    end
    arst_i = 0;

    // table vectors
    @(posedge clk_i); #1;
    for (int i = 0; i < 10; i++) begin
      start_i = tv[i].st; abort_i = tv[i].ab; m_ready_i = tv[i].rdy; samples_i = BUFFER_W'(tv[i].smp);
      @(posedge clk_i); #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("tbl%0d_busy%0d", i, d), bsy[d], tv[i].e_busy);
        chk($sformatf("tbl%0d_valid%0d", i, d), vld[d], tv[i].e_vld);
        chk($sformatf("tbl%0d_last%0d", i, d), lst[d], tv[i].e_last);
        chk($sformatf("tbl%0d_done%0d", i, d), dn[d], tv[i].e_done);
        if (tv[i].c_dat) chk($sformatf("tbl%0d_data%0d", i, d), dat[d], 32'(tv[i].e_dat));
      end
      chk($sformatf("tbl%0d_index1", i), 32'(idx1), 0);
      $display("vector %0d: st=%0d ab=%0d rdy=%0d smp=%0d -> busy=%0d valid=%0d done=%0d",
               i, tv[i].st, tv[i].ab, tv[i].rdy, tv[i].smp, bsy[0], vld[0], dn[0]);
    end
    start_i = 0; abort_i = 0;
    repeat (2) @(posedge clk_i);

    // directed readouts
    run(4, 4, 0, -1);
    run(2, 2, 0, -1);
    run(5, 7, 1, -1);
    run(0, 0, 0, -1);
    run(8, 8, 0, 2);
    run(3, 3, 0, -1);

    // asynchronous reset while a beat is stalled in OUT
    @(posedge clk_i); #1;
    start_i = 1; samples_i = 10'd3; m_ready_i = 0;
    @(posedge clk_i); #1;
    start_i = 0;
    repeat (READ_LAT + 3) @(posedge clk_i);
    #2;
    chk("pre_reset_valid", vld[0], 1);
    arst_i = 1;
    #1;
    chk("mid_reset_index1", 32'(idx1), 0);
    chk("mid_reset_index3", 32'(idx3), 0);
    chk("mid_reset_sel3", 32'(sel3), 0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mid_reset_data%0d", d), dat[d], 0);
      chk($sformatf("mid_reset_valid%0d", d), vld[d], 0);
      chk($sformatf("mid_reset_last%0d", d), lst[d], 0);
      chk($sformatf("mid_reset_busy%0d", d), bsy[d], 0);
      chk($sformatf("mid_reset_done%0d", d), dn[d], 0);
    end
    @(negedge clk_i);
    arst_i = 0;
    run(2, 9, 0, -1);

    // randomized readouts against the reference expectation
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, 12);
      run(n, $urandom_range(0, 15), 1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
